// File: rtl/word_reader_pkg.sv
// word_reader_pkg: shared FSM encoding and default sizes for the word reader,
// also used by the word_clipper integration.
package word_reader_pkg;

  localparam int DEF_ADDR_W  = 16;
  localparam int DEF_DATA_W  = 16;
  localparam int DEF_MAX_LEN = 16000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } readerState_e;

  // Inclusive index span clamped to maxLen; only meaningful when endIdx >= startIdx.
  function automatic logic [32:0] clampedLen(input logic [31:0] startIdx,
                                             input logic [31:0] endIdx,
                                             input logic [32:0] maxLen);
    logic [32:0] len;
    len = {1'b0, endIdx} - {1'b0, startIdx} + 33'd1;
    return (len > maxLen) ? maxLen : len;
  endfunction

endpackage

// File: rtl/word_reader_skid.sv
// word_reader_skid: 2-entry FIFO catching RAM read data so the downstream
// handshake can stall without losing or repeating a sample.
module word_reader_skid #(
  parameter int W = 17
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] data_i,
  output logic [1:0]   count_o,
  output logic [W-1:0] head_o
);

  logic [W-1:0] mem_q [2];
  logic         wrPtr_q;
  logic         rdPtr_q;
  logic [1:0]   count_q;
  logic         popEff;

  assign popEff  = pop_i && (count_q != 2'd0);
  assign count_o = count_q;
  assign head_o  = mem_q[rdPtr_q];

  // Storage, pointers and occupancy; push and pop may happen in the same cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wrPtr_q  <= 1'b0;
      rdPtr_q  <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push_i) begin
        mem_q[wrPtr_q] <= data_i;
        wrPtr_q        <= ~wrPtr_q;
      end
      if (popEff) begin
        rdPtr_q <= ~rdPtr_q;
      end
      count_q <= count_q + {1'b0, push_i} - {1'b0, popEff};
    end
  end

endmodule

// File: rtl/word_reader.sv
// word_reader: streams the samples of one clipped word out of the sample ring
// buffer with ready/valid and a last flag.
// Optional feature: define WORD_READER_PAD_EN to zero-pad every word to MAX_LEN beats.
module word_reader
  import word_reader_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int MAX_LEN = DEF_MAX_LEN
) (
  input  logic              iclk,
  input  logic              irst,
  input  logic              ivalid,
  input  logic [31:0]       istart_idx,
  input  logic [31:0]       iend_idx,
  output logic              obusy,
  output logic              odrop,
  output logic              omem_ren,
  output logic [ADDR_W-1:0] omem_addr,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic              ovalid,
  input  logic              iready,
  output logic [DATA_W-1:0] odata,
  output logic              olast
);

  localparam int          CNT_W     = $clog2(MAX_LEN + 1);
  localparam logic [32:0] MAX_LEN_W = 33'(MAX_LEN);

  readerState_e      state_q;
  logic [ADDR_W-1:0] startAddr_q;
  logic [CNT_W-1:0]  leff_q;
  logic [CNT_W-1:0]  issued_q;
  logic              drop_q;
  logic              inFlight_q;
  logic              inFlightZero_q;
  logic              inFlightLast_q;

  logic [CNT_W-1:0]  leff_d;
  logic [CNT_W-1:0]  target;
  logic              pop;
  logic [2:0]        occupancy;
  logic              canIssue;
  logic              issue;
  logic              issueZero;
  logic              issueLast;
  logic [DATA_W:0]   pushEntry;
  logic [DATA_W:0]   headEntry;
  logic [1:0]        fifoCount;

  // Read-issue decision: the beat being popped this cycle frees a slot, which
  // is what lets the pipeline sustain one beat per cycle without overflowing.
  always_comb begin
    leff_d = CNT_W'(clampedLen(istart_idx, iend_idx, MAX_LEN_W));
`ifdef WORD_READER_PAD_EN
    target = CNT_W'(MAX_LEN);
`else
    target = leff_q;
`endif
    pop       = ovalid & iready;
    occupancy = {1'b0, fifoCount} + {2'b0, inFlight_q};
    canIssue  = occupancy < (3'd2 + {2'b0, pop});
    issue     = (state_q == READ) && (issued_q < target) && canIssue;
    issueZero = (issued_q >= leff_q);
    issueLast = (issued_q == target - CNT_W'(1));
    pushEntry = {inFlightLast_q, inFlightZero_q ? {DATA_W{1'b0}} : imem_rdata};
  end

  assign obusy     = (state_q != IDLE);
  assign odrop     = drop_q;
  assign omem_ren  = issue & ~issueZero;
  assign omem_addr = startAddr_q + ADDR_W'(issued_q);
  assign ovalid    = (fifoCount != 2'd0);
  assign odata     = ovalid ? headEntry[DATA_W-1:0] : '0;
  assign olast     = ovalid & headEntry[DATA_W];

  // Request acceptance, read sequencing and the one-cycle read-return pipeline.
  always_ff @(posedge iclk or posedge irst) begin
    if (irst) begin
      state_q        <= IDLE;
      startAddr_q    <= '0;
      leff_q         <= '0;
      issued_q       <= '0;
      drop_q         <= 1'b0;
      inFlight_q     <= 1'b0;
      inFlightZero_q <= 1'b0;
      inFlightLast_q <= 1'b0;
    end else begin
      drop_q         <= 1'b0;
      inFlight_q     <= issue;
      inFlightZero_q <= issue & issueZero;
      inFlightLast_q <= issue & issueLast;
      case (state_q)
        IDLE: begin
          if (ivalid) begin
            if (iend_idx >= istart_idx) begin
              state_q     <= READ;
              startAddr_q <= istart_idx[ADDR_W-1:0];
              leff_q      <= leff_d;
              issued_q    <= '0;
            end else begin
              drop_q <= 1'b1;
            end
          end
        end
        READ: begin
          if (ivalid) drop_q <= 1'b1;
          if (issue) begin
            issued_q <= issued_q + CNT_W'(1);
            if (issueLast) state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (ivalid) drop_q <= 1'b1;
          if (pop && olast) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  word_reader_skid #(.W(DATA_W + 1)) skid (
    .clk_i   (iclk),
    .rst_i   (irst),
    .push_i  (inFlight_q),
    .pop_i   (pop),
    .data_i  (pushEntry),
    .count_o (fifoCount),
    .head_o  (headEntry)
  );

endmodule
